// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/divider_if.sv
// Start/ready handshake bundle shared between the execute stage and the divider.
interface divider_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               start;
  logic               is_signed;
  logic [2*WIDTH-1:0] s;
  logic               ready;
  logic               div_zero;

  modport master (
    output a, b, start, is_signed,
    input  s, ready, div_zero
  );

  modport slave (
    input  a, b, start, is_signed,
    output s, ready, div_zero
  );

endinterface

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration: shift {rem, quo} left, subtract the divisor when it fits.
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  localparam int RW = WIDTH + 1;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] divisor_ext;

  always_comb begin
    shifted     = {rem, quo[WIDTH-1]};
    divisor_ext = {2'b00, divisor};
    quo_next    = {quo[WIDTH-2:0], 1'b0};
    rem_next    = RW'(shifted);
    if (shifted >= divisor_ext) begin
      rem_next    = RW'(shifted - divisor_ext);
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/divider.sv
// DIV/DIVU restoring divider, one quotient bit per cycle, result packed as {remainder, quotient}.
// Optional DIVIDER_EARLY_EXIT_EN skips the iterations when b==0 or |a| < |b|.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic clk,
  input logic reset_n,
  divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t state;
  state_t state_next;

  logic ready;
  logic load;
  logic step_en;
  logic fix_en;
  logic early;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [2*WIDTH-1:0] s_q;
  logic               div_zero_q;

  always_comb begin
    a_abs = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
`ifdef DIVIDER_EARLY_EXIT_EN
    early = (bus.b == '0) || (a_abs < b_abs);
`else
    early = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = early ? FIX : CALC;
      CALC:    if (count == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready   = (state == IDLE);
    load    = (state == IDLE) && bus.start;
    step_en = (state == CALC);
    fix_en  = (state == FIX);
  end

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Divide by zero reports the raw dividend, bypassing any sign handling.
  always_comb begin
    q_fix = quo;
    r_fix = rem[WIDTH-1:0];
    if (b_zero) begin
      q_fix = '1;
      r_fix = a_raw;
    end else if (sgn) begin
      if (a_neg ^ b_neg) q_fix = -quo;
      if (a_neg)         r_fix = -rem[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sgn        <= 1'b0;
      a_neg      <= 1'b0;
      b_neg      <= 1'b0;
      b_zero     <= 1'b0;
      a_raw      <= '0;
      divisor    <= '0;
      rem        <= '0;
      quo        <= '0;
      count      <= '0;
      s_q        <= '0;
      div_zero_q <= 1'b0;
    end else if (load) begin
      sgn     <= bus.is_signed;
      a_neg   <= bus.a[WIDTH-1];
      b_neg   <= bus.b[WIDTH-1];
      b_zero  <= (bus.b == '0);
      a_raw   <= bus.a;
      divisor <= b_abs;
      count   <= CW'(WIDTH);
      if (early) begin
        rem <= {1'b0, a_abs};
        quo <= '0;
      end else begin
        rem <= '0;
        quo <= a_abs;
      end
    end else if (step_en) begin
      rem   <= rem_next;
      quo   <= quo_next;
      count <= count - CW'(1);
    end else if (fix_en) begin
      s_q        <= {r_fix, q_fix};
      div_zero_q <= b_zero;
    end
  end

  assign bus.ready    = ready;
  assign bus.s        = s_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vector table, hand sequences and a randomized reference model.
module tb_divider;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

`ifdef DIVIDER_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  logic [63:0] prev_s;

  divider_if bus ();

  divider dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MIPS DIV/DIVU semantics expressed with wide signed arithmetic; returns {div_zero, r, q}.
  function automatic logic [64:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint num;
    longint den;
    longint q;
    longint r;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sgn) begin
      num = longint'($signed(a));
      den = longint'($signed(b));
    end else begin
      num = longint'({32'd0, a});
      den = longint'({32'd0, b});
    end
    q = num / den;
    r = num % den;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  function automatic int exp_latency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (EARLY_EN && ((b == 32'd0) || (ma < mb))) return 2;
    return 34;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] eq, input logic [31:0] er, input logic edz,
                                input string name, input bit keep_start, input int poke_at);
    int n;
    bit hold_ok;
    @(negedge clk);
    bus.is_signed = sgn;
    bus.a         = a;
    bus.b         = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    n       = 1;
    hold_ok = 1'b1;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
    if (!keep_start) bus.start = 1'b0;
    while (!bus.ready && n < 100) begin
      if (bus.s !== prev_s) hold_ok = 1'b0;
      if (n == poke_at) bus.start = 1'b1;
      else if (!keep_start) bus.start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check_output({name, " latency"}, 64'(n), 64'(exp_latency(sgn, a, b)));
    check_output({name, " s"}, bus.s, {er, eq});
    check_output({name, " div_zero"}, 64'(bus.div_zero), 64'(edz));
    check_output({name, " s held while busy"}, 64'(hold_ok), 64'(1));
    prev_s = {er, eq};
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[15];
    logic [64:0] m;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    tests  = 0;
    fails  = 0;
    prev_s = '0;

    vecs = '{
      '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0},
      '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0},
      '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0},
      '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0},
      '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1},
      '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1},
      '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0},
      '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0},
      '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0},
      '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0},
      '{1'b1, 32'd5,          32'd7,          32'd0,          32'd5,          1'b0},
      '{1'b1, 32'hFFFF_FFFB,  32'd7,          32'd0,          32'hFFFF_FFFB,  1'b0},
      '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0},
      '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0},
      '{1'b1, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0001,  32'd0,          1'b0}
    };

    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset ready", 64'(bus.ready), 64'(1));
    check_output("reset s", bus.s, 64'd0);
    check_output("reset div_zero", 64'(bus.div_zero), 64'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
                     $sformatf("vec%0d", i), 1'b0, 0);
    end

    $display("[TB] busy start is ignored");
    apply_stimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "busy poke", 1'b0, 5);

    $display("[TB] back-to-back with start held");
    apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, "b2b first", 1'b1, 0);
    apply_stimulus(1'b0, 32'd15, 32'd16, 32'd0, 32'd15, 1'b0, "b2b second", 1'b0, 0);

    $display("[TB] reset mid-calculation");
    @(negedge clk);
    bus.is_signed = 1'b0;
    bus.a         = 32'hFFFF_FFFF;
    bus.b         = 32'd3;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_output("abort busy", 64'(bus.ready), 64'(0));
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_output("abort ready", 64'(bus.ready), 64'(1));
    check_output("abort s", bus.s, 64'd0);
    check_output("abort div_zero", 64'(bus.div_zero), 64'(0));
    reset_n = 1'b1;
    prev_s  = '0;

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 16);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 5);
        3: begin
          a = $urandom_range(0, 50);
          b = $urandom;
        end
        4: begin
          a = 32'h8000_0000;
          b = $urandom >> $urandom_range(0, 31);
        end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      m = model(sgn, a, b);
      apply_stimulus(sgn, a, b, m[31:0], m[63:32], m[64], $sformatf("rand%0d", i), 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
